// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: OPI opcodes, byte counts and the responder's FSM state encoding.
package psram_pkg;

  localparam logic [7:0] PSRAM_RD_CMD_DEF = 8'h20;
  localparam logic [7:0] PSRAM_WR_CMD_DEF = 8'hA0;
  localparam logic [7:0] PSRAM_WAIT_DEF   = 8'd6;

  localparam int unsigned PSRAM_CMD_BYTES  = 2;
  localparam int unsigned PSRAM_ADDR_BYTES = 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCmd    = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StRdata  = 3'd4;
  localparam logic [2:0] StWdata  = 3'd5;
  localparam logic [2:0] StIgnore = 3'd6;

endpackage

// File: rtl/psram_edge_sync.sv
// Brings the controller's sck and ce into the clk_i domain and derives DDR edge and ce transitions.
module psram_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ce_i,
  output logic sck_edge_o,
  output logic ce_fall_o,
  output logic ce_rise_o
);

  // [0] first sync stage, [1] synchronized level, [2] history for edge detection
  logic [2:0] sck_q;
  logic [2:0] ce_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q <= 3'b000;
      ce_q  <= 3'b111;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ce_q  <= {ce_q[1:0], ce_i};
    end
  end

  assign ce_fall_o  = ce_q[2] & ~ce_q[1];
  assign ce_rise_o  = ~ce_q[2] & ce_q[1];
  assign sck_edge_o = (sck_q[2] ^ sck_q[1]) & ~ce_q[1];

endmodule

// File: rtl/psram_opi_resp.sv
// Octal-SPI PSRAM device model: decodes linear-burst read/write commands and serves a byte array.
module psram_opi_resp
  import psram_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter logic [7:0]  RD_CMD  = PSRAM_RD_CMD_DEF,
  parameter logic [7:0]  WR_CMD  = PSRAM_WR_CMD_DEF,
  parameter logic [7:0]  RD_WAIT = PSRAM_WAIT_DEF,
  parameter logic [7:0]  WR_WAIT = PSRAM_WAIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic sck_edge, ce_fall, ce_rise;

  psram_edge_sync u_edge_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (psram_sck_i),
    .ce_i       (psram_ce_i),
    .sck_edge_o (sck_edge),
    .ce_fall_o  (ce_fall),
    .ce_rise_o  (ce_rise)
  );

  logic [2:0]    state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          is_rd_q, is_rd_d;
  logic          err_q, err_d;
  logic [7:0]    io_out_q, io_out_d;
  logic          io_en_q, io_en_d;
  logic          dqs_out_q, dqs_out_d;
  logic          dqs_en_q, dqs_en_d;

  logic [7:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [31:0]   addr_full;
  logic [8:0]    wait_edges;
  logic          unused_addr;

  assign unused_addr = ^addr_full[31:24];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    is_rd_d    = is_rd_q;
    err_d      = err_q;
    io_out_d   = io_out_q;
    io_en_d    = io_en_q;
    dqs_out_d  = dqs_out_q;
    dqs_en_d   = dqs_en_q;
    mem_we     = 1'b0;
    addr_full  = {addr_q, psram_io_in_i};
    wait_edges = is_rd_q ? {RD_WAIT, 1'b0} : {WR_WAIT, 1'b0};

    if (ce_rise) begin
      state_d   = StIdle;
      io_en_d   = 1'b0;
      dqs_en_d  = 1'b0;
      dqs_out_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // An sck edge coinciding with ce falling is already the first opcode byte
          if (ce_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            if (sck_edge) begin
              cmd_d = psram_io_in_i;
              cnt_d = 9'd1;
            end
          end
        end
        StCmd: begin
          if (sck_edge) begin
            if (cnt_q == '0) begin
              cmd_d = psram_io_in_i;
              cnt_d = 9'd1;
            end else begin
              cnt_d = '0;
              if (cmd_q == RD_CMD && psram_io_in_i == RD_CMD) begin
                state_d = StAddr;
                is_rd_d = 1'b1;
              end else if (cmd_q == WR_CMD && psram_io_in_i == WR_CMD) begin
                state_d = StAddr;
                is_rd_d = 1'b0;
              end else begin
                state_d = StIgnore;
                err_d   = 1'b1;
              end
            end
          end
        end
        StAddr: begin
          if (sck_edge) begin
            addr_d = addr_full[23:0];
            cnt_d  = cnt_q + 9'd1;
            if (cnt_q == 9'(PSRAM_ADDR_BYTES - 1)) begin
              cnt_d = '0;
              idx_d = {addr_full[IW-1:1], 1'b0};
              if (addr_full[0]) begin
                err_d = 1'b1;
              end
              if (is_rd_q) begin
                dqs_en_d  = 1'b1;
                dqs_out_d = 1'b0;
              end
              if (wait_edges == '0) begin
                state_d = is_rd_q ? StRdata : StWdata;
              end else begin
                state_d = StWait;
              end
            end
          end
        end
        StWait: begin
          if (sck_edge) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q + 9'd1 == wait_edges) begin
              state_d = is_rd_q ? StRdata : StWdata;
            end
          end
        end
        StRdata: begin
          if (sck_edge) begin
            io_out_d  = mem_q[idx_q];
            io_en_d   = 1'b1;
            dqs_out_d = ~dqs_out_q;
            idx_d     = idx_q + 1'b1;
          end
        end
        StWdata: begin
          if (sck_edge) begin
            mem_we = ~psram_dqs_in_i;
            idx_d  = idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
      io_out_q  <= '0;
      io_en_q   <= 1'b0;
      dqs_out_q <= 1'b0;
      dqs_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      is_rd_q   <= is_rd_d;
      err_q     <= err_d;
      io_out_q  <= io_out_d;
      io_en_q   <= io_en_d;
      dqs_out_q <= dqs_out_d;
      dqs_en_q  <= dqs_en_d;
    end
  end

  // Array contents deliberately survive rst_i
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= psram_io_in_i;
    end
  end

  assign psram_io_out_o  = io_out_q;
  assign psram_io_en_o   = {8{io_en_q}};
  assign psram_dqs_out_o = dqs_out_q;
  assign psram_dqs_en_o  = dqs_en_q;
  assign busy_o          = (state_q != StIdle);
  assign err_o           = err_q;

endmodule

// File: doc/psram_opi_resp.md
PSRAM_OPI_RESP -- requirements
Module: psram_opi_resp

Interface
REQ-001 Parameter DEPTH, 256, byte capacity of internal array; power of two, 16..4096.
REQ-002 Parameter RD_CMD, 8'h20, linear-burst read opcode (matches controller CMD.RDC default).
REQ-003 Parameter WR_CMD, 8'hA0, linear-burst write opcode (matches controller CMD.WRC default).
REQ-004 Parameter RD_WAIT, 8'd6, read latency in sck cycles; range 1..255.
REQ-005 Parameter WR_WAIT, 8'd6, write latency in sck cycles; range 0..255.
REQ-006 clk_i  in  1  sole clock; all state on its rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 psram_sck_i  in  1  bus clock from controller, asynchronous to clk_i, frequency at most clk_i/4.
REQ-009 psram_ce_i  in  1  chip enable, active-low.
REQ-010 psram_io_in_i  in  8  bus data driven by controller.
REQ-011 psram_io_out_o  out  8  read data toward controller.
REQ-012 psram_io_en_o  out  8  per-bit output enable, all-ones or all-zeros only.
REQ-013 psram_dqs_in_i  in  1  write data mask from controller; 1 = mask the byte.
REQ-014 psram_dqs_out_o  out  1  read strobe, toggles once per read byte.
REQ-015 psram_dqs_en_o  out  1  strobe output enable.
REQ-016 busy_o  out  1  high while a transaction is open (state not IDLE).
REQ-017 err_o  out  1  sticky error: unknown opcode, opcode mismatch, or odd start address; cleared only by rst_i.

Function
REQ-018 sck and ce SHALL each pass a 2-flop synchronizer plus a history flop; an "edge" is any change of synchronized sck while synchronized ce is low; each edge transfers exactly one byte (DDR).
REQ-019 io and dqs_in SHALL be sampled in the clk_i cycle the edge is detected (controller holds them stable for at least 4 clk_i).
REQ-020 FSM states: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
REQ-021 IDLE -> CMD on synchronized ce falling; CMD captures 2 bytes; both equal RD_CMD or both equal WR_CMD -> ADDR, else set err_o -> IGNORE.
REQ-022 ADDR captures 4 bytes MSB first into a 32-bit address; array index = address mod DEPTH; an odd address SHALL set err_o and clear bit 0.
REQ-023 WAIT consumes 2*RD_WAIT (read) or 2*WR_WAIT (write) edges, then -> RDATA or WDATA; WR_WAIT = 0 goes directly to WDATA.
REQ-024 Read: from WAIT entry, dqs_en_o = 1 and dqs_out_o = 0; io_en_o stays 0 during WAIT.
REQ-025 RDATA: on each edge, io_out_o = mem[index], io_en_o = 8'hFF, dqs_out_o toggles, index increments mod DEPTH (wrap to 0), all in the same clk_i cycle.
REQ-026 WDATA: on each edge, mem[index] = io_in_i unless dqs_in_i = 1; index increments mod DEPTH regardless of the mask.
REQ-027 No burst-length limit; a write of one byte is committed (controller's 2-byte minimum is not enforced).
REQ-028 Synchronized ce rising in any state -> IDLE next clk_i; io_en_o, dqs_en_o, dqs_out_o -> 0; a partial CMD/ADDR is discarded without error.
REQ-029 IGNORE drives nothing and stays until ce rises.
REQ-030 Edges while ce is high are ignored; ce falling and an sck edge in the same synchronized cycle: ce takes effect first, and the edge counts as CMD byte 0.

Reset
REQ-031 rst_i SHALL force state IDLE, io_out_o = 0, io_en_o = 0, dqs_out_o = 0, dqs_en_o = 0, busy_o = 0, err_o = 0, and clear synchronizers to sck = 0, ce = 1.
REQ-032 Reset mid-transaction SHALL abort the transaction; array contents are not reset; bytes already written remain.

Structure
REQ-033 State enum, opcode defaults and OPI byte counts (CMD = 2, ADDR = 4) SHALL live in a shared package psram_pkg alongside the existing PSRAM defines.
REQ-034 One sub-module, psram_edge_sync (2-flop sync + edge/level outputs for sck and ce), is natural; the array is an inferred register/RAM inside this module.

Verification
REQ-035 Write A0 A0, addr 0x00000010, 12 wait edges, bytes 11 22 33 44, then read 20 20 same addr -> after 12 wait edges, 4 dqs toggles carrying 11 22 33 44; err_o = 0.
REQ-036 Write at addr DEPTH-2 of bytes AA BB CC DD -> a read from 0 returns CC DD; a read from DEPTH-2 returns AA BB.
REQ-037 Write 01 02 03 with dqs_in = 0,1,0 at addr 0x20 over prior FF FF FF -> a read returns 01 FF 03.
REQ-038 Opcode bytes 20 A0 -> err_o = 1, io_en_o stays 0 until ce rises, busy_o drops 3 clk_i after ce rises.
REQ-039 ce raised after 2 address bytes, then a normal read of 0x10 -> correct data, err_o = 0; rst_i pulsed during RDATA -> all outputs 0 next cycle, array intact.
REQ-040 Read at odd addr 0x11 -> err_o = 1 and data streams from 0x10.
